// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter that shares one pipelined ALU (latency LAT) among
//   NUM_REQ requesters. At most one request is granted per cycle. The granted
//   operands drive the ALU directly. A {valid, id} tag pipeline follows each op
//   through the ALU, so every result comes back tagged with its requester. A
//   RUN/DRAIN/PAUSED state machine lets software stop issue and wait until
//   every op in flight has returned.
//
// Optional feature:
//   ALU_ARB_STATS_EN - when defined, op_count counts accepted requests and
//                      saturates at 16'hFFFF. When undefined, op_count is
//                      tied to zero.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or 0)
//   req_a/req_b/req_ctrl  packed per-requester operands and op code
//   alu_a/alu_b/alu_ctrl  drive to the ALU (zero when nothing is granted)
//   alu_z/alu_zero        ALU result register and zero flag
//   pause_req/paused      drain request and quiesced status
//   rsp_valid/rsp_id      tagged response, aligned with alu_z/alu_zero
//   rsp_z/rsp_zero        result pass-through
//   op_count              accepted-op counter (optional feature)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int LAT     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [1:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_z,
  input  logic                      alu_zero,
  input  logic                      pause_req,
  output logic                      paused,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_z,
  output logic                      rsp_zero,
  output logic [15:0]               op_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [LAT-1:0]     r_tag_vld;
  logic [IDX_W-1:0]   r_tag_id [LAT];

  logic               w_issue_en;
  logic               w_grant_any;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_pipe_empty;

  logic [DATA_W-1:0]  w_a_lane    [NUM_REQ];
  logic [DATA_W-1:0]  w_b_lane    [NUM_REQ];
  logic [1:0]         w_ctrl_lane [NUM_REQ];

  // Unpack the flat request buses once so the mux below indexes by requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_a_lane[gi]    = req_a[gi*DATA_W +: DATA_W];
    assign w_b_lane[gi]    = req_b[gi*DATA_W +: DATA_W];
    assign w_ctrl_lane[gi] = req_ctrl[gi*2 +: 2];
  end

  assign w_issue_en   = (r_state == ST_RUN) && !pause_req;
  assign w_pipe_empty = ~|r_tag_vld;

  // Round-robin search: walk from r_rr_ptr upward with wrap, keep the first hit.
  // NOTE: every variable written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (w_issue_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_grant_any && req_valid[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant;

  // ALU inputs are forced to zero when idle so the ALU sees a benign ADD 0+0.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 2'b00;
    if (w_grant_any) begin
      alu_a    = w_a_lane[w_grant_idx];
      alu_b    = w_b_lane[w_grant_idx];
      alu_ctrl = w_ctrl_lane[w_grant_idx];
    end
  end

  // Pointer and tag pipeline. Stage 0 loads on the same edge the ALU samples
  // its inputs, so stage LAT-1 lines up with the ALU result register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter how the statements are ordered.
  // NOTE: the tag array is reset on purpose; a reset mid-stream must drop all
  // in-flight ops rather than let stale valid bits emerge as responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_tag_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      if (w_grant_any) begin
        r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      r_tag_vld[0] <= w_grant_any;
      r_tag_id[0]  <= w_grant_idx;
      for (int s = 1; s < LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  // Pause/drain state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (pause_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Abandoning the pause takes priority over completing the drain.
        if (!pause_req)        w_state_nxt = ST_RUN;
        else if (w_pipe_empty) w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!pause_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign paused    = (r_state == ST_PAUSED);
  assign rsp_valid = r_tag_vld[LAT-1];
  assign rsp_id    = 3'(r_tag_id[LAT-1]);
  assign rsp_z     = alu_z;
  assign rsp_zero  = alu_zero;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_grant_any && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed self-checking bench for alu_arbiter (NUM_REQ=4, DATA_W=4, LAT=2).
//   A small 2-stage ALU model closes the loop between alu_* outputs and the
//   alu_z/alu_zero inputs. Expected values are hand-computed constants.
//   op_count checks follow ALU_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*2-1:0]      req_ctrl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [1:0]                alu_ctrl;
  logic [DATA_W-1:0]         alu_z    = '0;
  logic                      alu_zero = 1'b1;
  logic                      pause_req;
  logic                      paused;
  logic                      rsp_valid;
  logic [2:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_z;
  logic                      rsp_zero;
  logic [15:0]               op_count;

  logic [DATA_W-1:0]         alu_s1 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_z     (alu_z),
    .alu_zero  (alu_zero),
    .pause_req (pause_req),
    .paused    (paused),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_zero  (rsp_zero),
    .op_count  (op_count)
  );

  // Two-stage ALU: operate on the sample edge, register the result next edge.
  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0] c);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_s1   <= alu_f(alu_a, alu_b, alu_ctrl);
    alu_z    <= alu_s1;
    alu_zero <= (alu_s1 == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ops(input string tag, input int n);
`ifdef ALU_ARB_STATS_EN
    check(tag, 32'(op_count), n);
`else
    check(tag, 32'(op_count), 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] c);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
    req_ctrl[i*2 +: 2]        = c;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    pause_req = 1'b0;
    step();
    step();
    rst = 1'b0;

    // ---- reset state and single request ----
    #1;
    check("rst_paused", 32'(paused), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check_ops("rst_op_count", 0);
    check("rst_ready_idle", 32'(req_ready), 0);
    set_lane(0, 4'd3, 4'd5, 2'b00);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0001);
    check("t1_alu_a", 32'(alu_a), 3);
    check("t1_alu_b", 32'(alu_b), 5);
    check("t1_alu_ctrl", 32'(alu_ctrl), 0);
    step();
    req_valid = '0;
    #1;
    check("t1_alu_idle_a", 32'(alu_a), 0);
    check("t1_rsp_early", 32'(rsp_valid), 0);
    step();
    #1;
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_id", 32'(rsp_id), 0);
    check("t1_rsp_z", 32'(rsp_z), 8);
    check("t1_rsp_zero", 32'(rsp_zero), 0);
    step();

    // ---- all requesters, SUB 7-7, round-robin order ----
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 4'd7, 4'd7, 2'b01);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8) ? 4'hF : 4'h0;
      #1;
      if (i < 8) check("t2_grant", 32'(req_ready), 32'(1 << (i % 4)));
      if (i >= 2) begin
        check("t2_rsp_valid", 32'(rsp_valid), 1);
        check("t2_rsp_id", 32'(rsp_id), (i - 2) % 4);
        check("t2_rsp_z", 32'(rsp_z), 0);
        check("t2_rsp_zero", 32'(rsp_zero), 1);
      end
      step();
    end

    // ---- fairness: grant 1 moves the pointer to 2, then 0011 wraps to 0 ----
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 4'd0, 4'd0, 2'b00);
    req_valid = 4'b0010;
    #1;
    check("t3_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0011;
    #1;
    check("t3_wrap0", 32'(req_ready), 32'b0001);
    step();
    #1;
    check("t3_then1", 32'(req_ready), 32'b0010);
    step();
    #1;
    check("t3_then0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    step();

    // ---- back-to-back ops from requester 2 ----
    set_lane(2, 4'hC, 4'hA, 2'b10);
    req_valid = 4'b0100;
    #1;
    check("t4_grant_a", 32'(req_ready), 32'b0100);
    check("t4_alu_ctrl", 32'(alu_ctrl), 2);
    check("t4_idle_valid0", 32'(rsp_valid), 0);
    check("t4_idle_zero0", 32'(rsp_zero), 1);
    step();
    set_lane(2, 4'hF, 4'hF, 2'b11);
    #1;
    check("t4_grant_b", 32'(req_ready), 32'b0100);
    check("t4_idle_valid1", 32'(rsp_valid), 0);
    step();
    req_valid = '0;
    #1;
    check("t4_rsp1_valid", 32'(rsp_valid), 1);
    check("t4_rsp1_id", 32'(rsp_id), 2);
    check("t4_rsp1_z", 32'(rsp_z), 8);
    check("t4_rsp1_zero", 32'(rsp_zero), 0);
    step();
    #1;
    check("t4_rsp2_valid", 32'(rsp_valid), 1);
    check("t4_rsp2_id", 32'(rsp_id), 2);
    check("t4_rsp2_z", 32'(rsp_z), 0);
    check("t4_rsp2_zero", 32'(rsp_zero), 1);
    step();
    #1;
    check("t4_idle_valid2", 32'(rsp_valid), 0);
    check("t4_idle_zero2", 32'(rsp_zero), 1);
    step();

    // ---- pause with two ops in flight ----
    set_lane(0, 4'd1, 4'd2, 2'b00);
    set_lane(1, 4'd9, 4'd4, 2'b01);
    req_valid = 4'b0011;
    #1;
    check("t5_grant0", 32'(req_ready), 32'b0001);
    step();
    #1;
    check("t5_grant1", 32'(req_ready), 32'b0010);
    step();
    pause_req = 1'b1;
    #1;
    check("t5_c2_ready", 32'(req_ready), 0);
    check("t5_c2_rsp_valid", 32'(rsp_valid), 1);
    check("t5_c2_rsp_id", 32'(rsp_id), 0);
    check("t5_c2_rsp_z", 32'(rsp_z), 3);
    check("t5_c2_paused", 32'(paused), 0);
    step();
    #1;
    check("t5_c3_ready", 32'(req_ready), 0);
    check("t5_c3_rsp_valid", 32'(rsp_valid), 1);
    check("t5_c3_rsp_id", 32'(rsp_id), 1);
    check("t5_c3_rsp_z", 32'(rsp_z), 5);
    check("t5_c3_paused", 32'(paused), 0);
    step();
    #1;
    check("t5_c4_ready", 32'(req_ready), 0);
    check("t5_c4_rsp_valid", 32'(rsp_valid), 0);
    check("t5_c4_paused", 32'(paused), 0);
    step();
    #1;
    check("t5_c5_paused", 32'(paused), 1);
    check("t5_c5_ready", 32'(req_ready), 0);
    pause_req = 1'b0;
    #1;
    check("t5_c5_ready_unpause", 32'(req_ready), 0);
    step();
    #1;
    check("t5_c6_paused", 32'(paused), 0);
    check("t5_c6_resume", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    #1;
    check_ops("t5_op_count", 17);
    step();
    step();

    // ---- reset mid-stream ----
    reset_dut();
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t6_grant", 32'(req_ready), 32'(1 << (i % 4)));
      step();
    end
    req_valid = '0;
    #1;
    check_ops("t6_op_count_pre", 10);
    check("t6_rsp_pre_id", 32'(rsp_id), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_rsp_dropped", 32'(rsp_valid), 0);
      check("t6_paused", 32'(paused), 0);
      check_ops("t6_op_count_post", 0);
      step();
    end
    req_valid = 4'hF;
    #1;
    check("t6_ptr_reset", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter that shares one 2-stage pipelined 4-bit ALU among NUM_REQ requesters.
- Selects at most one request per cycle and drives the ALU operand and control inputs.
- Tracks the requester ID of each in-flight op through the ALU latency and returns each result tagged with that ID.
- A pause/drain state machine lets software quiesce the ALU with no ops lost.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, operand/result width; matches the ALU
- LAT, 2, ALU latency in clocks, from input sample edge to result register

Ports:
- clk, input, 1, clock; all logic on rising edge
- rst, input, 1, synchronous active-high reset
- req_valid, input, NUM_REQ, per-requester request valid
- req_ready, output, NUM_REQ, one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
- req_a, input, NUM_REQ*DATA_W, operand A; requester i occupies bits [i*DATA_W +: DATA_W]
- req_b, input, NUM_REQ*DATA_W, operand B; same packing as req_a
- req_ctrl, input, NUM_REQ*2, op code: 00 ADD, 01 SUB, 10 AND, 11 XOR
- alu_a, output, DATA_W, to ALU operand A
- alu_b, output, DATA_W, to ALU operand B
- alu_ctrl, output, 2, to ALU ctrl
- alu_z, input, DATA_W, from ALU result register
- alu_zero, input, 1, from ALU zero flag register
- pause_req, input, 1, request to stop issuing and drain
- paused, output, 1, ALU idle and no ops in flight
- rsp_valid, output, 1, result valid (no backpressure)
- rsp_id, output, 3, requester index of the result
- rsp_z, output, DATA_W, result value
- rsp_zero, output, 1, result zero flag
- op_count, output, 16, accepted-op counter (optional feature)

Behaviour:
- Reset (sync): rr pointer = 0, so requester 0 has highest priority. Tag pipeline cleared. FSM = RUN.
- Reset output values: paused=0, rsp_valid=0, rsp_id=0, op_count=0. req_ready follows the grant logic from the first cycle after reset.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them.
- Grant (combinational):
  - issue_en = (state==RUN) & ~pause_req.
  - When issue_en is high, grant the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot or all zero. It never asserts for a requester whose req_valid is low.
- rr_ptr update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. On no grant, rr_ptr holds.
- ALU drive (combinational):
  - With a grant: alu_a, alu_b and alu_ctrl = the granted requester's fields.
  - With no grant: alu_a=0, alu_b=0, alu_ctrl=00.
- Tag pipeline: LAT stages of {vld, id}.
  - Stage 0 loads {grant_any, g} on the same edge the ALU samples its inputs.
  - Each stage shifts every cycle.
- Response outputs:
  - rsp_valid = vld of stage LAT-1; rsp_id = id of stage LAT-1.
  - rsp_z = alu_z and rsp_zero = alu_zero, passed through combinationally.
  - A request granted in cycle N produces its response in cycle N+LAT.
- Throughput: one op per cycle sustained. No stalls; consumers must accept rsp each cycle.
- FSM transitions:
  - RUN -> DRAIN when pause_req=1. No grant in any cycle where pause_req=1.
  - DRAIN -> PAUSED when all tag vld bits = 0.
  - DRAIN -> RUN when pause_req=0, with priority over DRAIN -> PAUSED.
  - PAUSED -> RUN when pause_req=0. Issue resumes the cycle after the FSM enters RUN.
  - paused = (state==PAUSED).
- Simultaneous pause_req and drain-complete: the DRAIN -> PAUSED transition is taken.
- rsp_valid continues during DRAIN until the pipeline is empty.
- Illegal requester index never occurs: the rsp_id upper bits are 0 when NUM_REQ<8.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: op_count increments by 1 on every accepted request, saturates at 16'hFFFF, and is cleared by rst.
- Undefined: op_count tied to 0 and no counter flops are inferred.

Test Plan:
- Single request after reset: rst 2 cycles, then req_valid=0001, a=3, b=5, ctrl=00. req_ready=0001 same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_z=8, rsp_zero=0.
- All requesters valid for 8 cycles, all with SUB a=b=7: grants 0,1,2,3,0,1,2,3. Responses appear LAT cycles behind in the same ID order, each with rsp_z=0, rsp_zero=1.
- Fairness with rr_ptr=2 after a grant to requester 1: req_valid=0011. Grant goes to 0 (wrap), then 1; requester 1 is never granted twice in a row while 0 is waiting.
- Back-to-back ops from requester 2: AND(C,A) then XOR(F,F). Responses on consecutive cycles, rsp_z=8 then 0 with rsp_zero=1. Idle cycles give rsp_valid=0 even though alu_zero=1.
- Pause with 2 ops in flight, pause_req held high: no grants; rsp_valid on the next 2 cycles, then paused=1. Drop pause_req: paused=0 and grants resume the following cycle.
- Reset mid-stream: rst for 1 cycle with 2 ops in flight. No rsp_valid afterwards, rr_ptr=0, and op_count=0 (with ALU_ARB_STATS_EN; 10 accepted ops before reset read op_count=10).
